// File: rtl/mor1kx_fetch_prefetch_pkg.sv
// Shared constants and fetch FSM encoding for the prefetching fetch unit.
package mor1kx_fetch_prefetch_pkg;

    localparam logic [4:0]  OR1K_RESET_VECTOR = 5'h01;
    localparam logic [5:0]  OR1K_OPCODE_NOP   = 6'h05;
    localparam logic [31:0] OR1K_NOP_INSN     = {OR1K_OPCODE_NOP, 26'd0};

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StFetch   = 2'd1,
        StDrain   = 2'd2,
        StErrWait = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/mor1kx_fetch_prefetch_if.sv
// Instruction bus between the fetch unit (master) and the cache or bus bridge (slave).
interface mor1kx_fetch_prefetch_if #(
    parameter int unsigned OPTION_OPERAND_WIDTH = 32
);
    logic [OPTION_OPERAND_WIDTH-1:0] ibus_adr;
    logic                            ibus_req;
    logic                            ibus_burst;
    logic                            ibus_ack;
    logic                            ibus_err;
    logic [31:0]                     ibus_dat;

    modport master (
        output ibus_adr, ibus_req, ibus_burst,
        input  ibus_ack, ibus_err, ibus_dat
    );

    modport slave (
        input  ibus_adr, ibus_req, ibus_burst,
        output ibus_ack, ibus_err, ibus_dat
    );
endinterface

// File: rtl/mor1kx_fetch_fifo.sv
// Synchronous FIFO with single-cycle flush; head is read straight from registered storage.
module mor1kx_fetch_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 8,
    parameter int unsigned CntW  = $clog2(Depth) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);
    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_push = push_i & (~full_o | pop_i);
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/mor1kx_fetch_prefetch.sv
// Prefetching fetch unit: keeps a small queue of {insn, pc, err} ahead of decode and
// handles redirects by flushing the queue and draining any in-flight bus access.
module mor1kx_fetch_prefetch
    import mor1kx_fetch_prefetch_pkg::*;
#(
    parameter int unsigned OPTION_OPERAND_WIDTH = 32,
    parameter int unsigned OPTION_RF_ADDR_WIDTH = 5,
    parameter logic [OPTION_OPERAND_WIDTH-1:0] OPTION_RESET_PC =
        OPTION_OPERAND_WIDTH'({19'd0, OR1K_RESET_VECTOR, 8'd0}),
    parameter int unsigned FETCH_DEPTH = 4,
    parameter string FEATURE_BURST = "ENABLED"
) (
    input  logic                            clk,
    input  logic                            rst,
    mor1kx_fetch_prefetch_if.master         ibus,
    input  logic                            redirect_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] redirect_pc_i,
    input  logic                            exception_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] exception_pc_i,
    input  logic                            du_restart_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] du_restart_pc_i,
    input  logic                            du_stall_i,
    input  logic                            stepping_i,
    input  logic                            decode_ready_i,
    output logic                            decode_valid_o,
    output logic [31:0]                     decode_insn_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] decode_pc_o,
    output logic                            decode_ibus_err_o,
    output logic [OPTION_RF_ADDR_WIDTH-1:0] fetch_rfa_adr_o,
    output logic [OPTION_RF_ADDR_WIDTH-1:0] fetch_rfb_adr_o
);
    localparam int unsigned CntW  = $clog2(FETCH_DEPTH) + 1;
    localparam int unsigned DataW = 32 + OPTION_OPERAND_WIDTH + 1;
    localparam bit          BurstEn = (FEATURE_BURST == "ENABLED");

    fetch_state_e                    state_q, state_d;
    logic [OPTION_OPERAND_WIDTH-1:0] pc_fetch_q, pc_fetch_d;
    logic [OPTION_OPERAND_WIDTH-1:0] drain_adr_q, drain_adr_d;
    logic [OPTION_OPERAND_WIDTH-1:0] redir_pc, head_pc;
    logic [31:0]                     head_insn;
    logic [CntW-1:0]                 count;
    logic                            fifo_full, fifo_empty, head_err;
    logic                            redir, outstanding, resp, push, pop, can_fetch;
    int unsigned                     cnt_after, space;

    assign redir    = du_restart_i | exception_i | redirect_i;
    assign redir_pc = du_restart_i ? du_restart_pc_i :
                      exception_i  ? exception_pc_i  : redirect_pc_i;

    assign outstanding = (state_q == StFetch) || (state_q == StDrain);
    assign resp        = ibus.ibus_ack | ibus.ibus_err;
    assign pop         = decode_valid_o & decode_ready_i;
    assign push        = (state_q == StFetch) & resp & ~redir & (~fifo_full | pop);

    // Occupancy as it will be after this edge; decides whether the next request may go out.
    assign cnt_after = 32'(count) + 32'(push) - 32'(pop);
    assign space     = FETCH_DEPTH - 32'(count) - 32'(outstanding);
    assign can_fetch = !du_stall_i && (cnt_after < FETCH_DEPTH) &&
                       (!stepping_i || cnt_after == 0);

    always_comb begin
        state_d     = state_q;
        pc_fetch_d  = pc_fetch_q;
        drain_adr_d = drain_adr_q;
        if (redir) begin
            pc_fetch_d = redir_pc;
            if (outstanding && !resp) begin
                state_d = StDrain;
                if (state_q == StFetch) drain_adr_d = pc_fetch_q;
            end else begin
                state_d = du_stall_i ? StIdle : StFetch;
            end
        end else begin
            unique case (state_q)
                StIdle: if (can_fetch) state_d = StFetch;
                StFetch: begin
                    if (ibus.ibus_err) begin
                        state_d = StErrWait;
                    end else if (ibus.ibus_ack) begin
                        pc_fetch_d = pc_fetch_q + OPTION_OPERAND_WIDTH'(4);
                        if (!can_fetch) state_d = StIdle;
                    end
                end
                StDrain: if (resp) state_d = can_fetch ? StFetch : StIdle;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            pc_fetch_q  <= OPTION_RESET_PC;
            drain_adr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_fetch_q  <= pc_fetch_d;
            drain_adr_q <= drain_adr_d;
        end
    end

    // While draining, the bus still sees the address of the abandoned access.
    assign ibus.ibus_req   = outstanding;
    assign ibus.ibus_adr   = (state_q == StDrain) ? drain_adr_q : pc_fetch_q;
    assign ibus.ibus_burst = BurstEn && (state_q == StFetch) && (space >= 2) &&
                             (pc_fetch_q[3:2] != 2'b11);

    mor1kx_fetch_fifo #(
        .Depth (FETCH_DEPTH),
        .Width (DataW),
        .CntW  (CntW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redir),
        .push_i  (push),
        .data_i  ({ibus.ibus_dat, pc_fetch_q, ibus.ibus_err}),
        .pop_i   (pop),
        .data_o  ({head_insn, head_pc, head_err}),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count)
    );

    assign decode_valid_o    = ~fifo_empty;
    assign decode_insn_o     = fifo_empty ? OR1K_NOP_INSN : head_insn;
    assign decode_pc_o       = fifo_empty ? '0 : head_pc;
    assign decode_ibus_err_o = ~fifo_empty & head_err;
    assign fetch_rfa_adr_o   = decode_insn_o[16 +: OPTION_RF_ADDR_WIDTH];
    assign fetch_rfb_adr_o   = decode_insn_o[11 +: OPTION_RF_ADDR_WIDTH];

endmodule

// File: tb/tb_mor1kx_fetch_prefetch.sv
// Directed bench for the prefetching fetch unit; decode hand-overs are scored against a queue.
module tb_mor1kx_fetch_prefetch;
    import mor1kx_fetch_prefetch_pkg::*;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0, exception = 1'b0, du_restart = 1'b0;
    logic [31:0] redirect_pc = '0, exception_pc = '0, du_restart_pc = '0;
    logic        du_stall = 1'b0, stepping = 1'b0, dec_ready = 1'b0;
    logic        dec_valid, dec_err;
    logic [31:0] dec_insn, dec_pc;
    logic [4:0]  rfa, rfb;
    logic [3:0]  burst_tab;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    mor1kx_fetch_prefetch_if #(.OPTION_OPERAND_WIDTH(32)) ibus_if ();

    mor1kx_fetch_prefetch dut (
        .clk               (clk),
        .rst               (rst),
        .ibus              (ibus_if),
        .redirect_i        (redirect),
        .redirect_pc_i     (redirect_pc),
        .exception_i       (exception),
        .exception_pc_i    (exception_pc),
        .du_restart_i      (du_restart),
        .du_restart_pc_i   (du_restart_pc),
        .du_stall_i        (du_stall),
        .stepping_i        (stepping),
        .decode_ready_i    (dec_ready),
        .decode_valid_o    (dec_valid),
        .decode_insn_o     (dec_insn),
        .decode_pc_o       (dec_pc),
        .decode_ibus_err_o (dec_err),
        .fetch_rfa_adr_o   (rfa),
        .fetch_rfb_adr_o   (rfb)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [63:0] got, logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endfunction

    // Monitor: every decode hand-over must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && dec_valid && dec_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got pc %0h, expected no hand-over", dec_pc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pop_pc", dec_pc, mon_e.pc);
                chk("pop_insn", dec_insn, mon_e.insn);
                chk("pop_err", dec_err, mon_e.err);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        dec_ready = 1'b0;
        stepping = 1'b0;
        ibus_if.ibus_ack = 1'b0;
        ibus_if.ibus_err = 1'b0;
        exp_q.delete();
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    // Respond to the current request; accepted data is expected at decode later.
    task automatic issue(input logic [31:0] pc, input logic [31:0] dat, input logic err);
        chk("req_before_resp", ibus_if.ibus_req, 1'b1);
        chk("req_adr", ibus_if.ibus_adr, pc);
        ibus_if.ibus_ack = ~err;
        ibus_if.ibus_err = err;
        ibus_if.ibus_dat = dat;
        exp_q.push_back('{pc: pc, insn: dat, err: err});
        cyc();
        ibus_if.ibus_ack = 1'b0;
        ibus_if.ibus_err = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1);
    end

    initial begin
        ibus_if.ibus_ack = 1'b0;
        ibus_if.ibus_err = 1'b0;
        ibus_if.ibus_dat = '0;

        // Reset values, then streaming fetch with decode always ready.
        cyc();
        cyc();
        chk("rst_req", ibus_if.ibus_req, 1'b0);
        chk("rst_valid", dec_valid, 1'b0);
        chk("rst_insn", dec_insn, 32'h1400_0000);
        chk("rst_pc", dec_pc, 32'h0);
        chk("rst_err", dec_err, 1'b0);
        rst = 1'b0;
        dec_ready = 1'b1;
        cyc();
        chk("s1_first_req", ibus_if.ibus_req, 1'b1);
        chk("s1_burst", ibus_if.ibus_burst, 1'b1);
        for (int i = 0; i < 3; i++) begin
            issue(32'h100 + 32'(4 * i), 32'hE0A3_2000 + 32'(i), 1'b0);
            chk("s1_head_valid", dec_valid, 1'b1);
            chk("s1_head_pc", dec_pc, 32'h100 + 32'(4 * i));
            if (i == 0) begin
                chk("s1_rfa", rfa, 5'd3);
                chk("s1_rfb", rfb, 5'd4);
            end
        end
        repeat (3) cyc();
        chk("s1_drained", exp_q.size(), 0);

        // Fill to depth with decode stalled; one pop frees one request.
        reset_dut();
        burst_tab = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            chk("s2_burst", ibus_if.ibus_burst, burst_tab[i]);
            issue(32'h100 + 32'(4 * i), 32'h1000_0000 + 32'(i), 1'b0);
        end
        chk("s2_full_req", ibus_if.ibus_req, 1'b0);
        cyc();
        chk("s2_full_req_hold", ibus_if.ibus_req, 1'b0);
        dec_ready = 1'b1;
        cyc();
        dec_ready = 1'b0;
        issue(32'h110, 32'h1000_0004, 1'b0);
        chk("s2_refull_req", ibus_if.ibus_req, 1'b0);
        dec_ready = 1'b1;
        repeat (6) cyc();
        chk("s2_drained", exp_q.size(), 0);

        // Redirect with an access outstanding: flush, drain, refetch at target.
        reset_dut();
        for (int i = 0; i < 3; i++) issue(32'h100 + 32'(4 * i), 32'h2000_0000 + 32'(i), 1'b0);
        redirect = 1'b1;
        redirect_pc = 32'h2000;
        exp_q.delete();
        cyc();
        redirect = 1'b0;
        chk("s3_flushed", dec_valid, 1'b0);
        chk("s3_drain_req", ibus_if.ibus_req, 1'b1);
        chk("s3_drain_adr", ibus_if.ibus_adr, 32'h10C);
        chk("s3_drain_burst", ibus_if.ibus_burst, 1'b0);
        dec_ready = 1'b1;
        cyc();
        chk("s3_drain_adr_hold", ibus_if.ibus_adr, 32'h10C);
        ibus_if.ibus_ack = 1'b1;
        ibus_if.ibus_dat = 32'hDEAD_BEEF;
        cyc();
        ibus_if.ibus_ack = 1'b0;
        chk("s3_discarded", dec_valid, 1'b0);
        issue(32'h2000, 32'h2000_2000, 1'b0);
        repeat (3) cyc();
        chk("s3_drained", exp_q.size(), 0);

        // Bus error parks the fetcher until an exception redirect.
        reset_dut();
        issue(32'h100, 32'h3000_0000, 1'b0);
        issue(32'h104, 32'h3000_0004, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("s4_errwait_req", ibus_if.ibus_req, 1'b0);
            cyc();
        end
        dec_ready = 1'b1;
        cyc();
        chk("s4_err_head_pc", dec_pc, 32'h104);
        chk("s4_err_head_err", dec_err, 1'b1);
        cyc();
        chk("s4_errwait_empty_req", ibus_if.ibus_req, 1'b0);
        exception = 1'b1;
        exception_pc = 32'h600;
        cyc();
        exception = 1'b0;
        issue(32'h600, 32'h3000_0600, 1'b0);
        repeat (3) cyc();
        chk("s4_drained", exp_q.size(), 0);

        // Debug restart beats redirect; the ack in that cycle is dropped.
        reset_dut();
        chk("s5_adr", ibus_if.ibus_adr, 32'h100);
        ibus_if.ibus_ack = 1'b1;
        ibus_if.ibus_dat = 32'hBAD0_0100;
        du_restart = 1'b1;
        du_restart_pc = 32'h4000;
        redirect = 1'b1;
        redirect_pc = 32'h2000;
        cyc();
        ibus_if.ibus_ack = 1'b0;
        du_restart = 1'b0;
        redirect = 1'b0;
        chk("s5_discarded", dec_valid, 1'b0);
        issue(32'h4000, 32'h4000_4000, 1'b0);
        dec_ready = 1'b1;
        repeat (3) cyc();
        chk("s5_drained", exp_q.size(), 0);

        // Single-step: one instruction in flight or buffered; no burst at end of line.
        reset_dut();
        stepping = 1'b1;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        burst_tab = 4'b0111;
        for (int i = 0; i < 4; i++) begin
            chk("s6_burst", ibus_if.ibus_burst, burst_tab[i]);
            issue(32'h100 + 32'(4 * i), 32'h5000_0000 + 32'(i), 1'b0);
            chk("s6_wait_req", ibus_if.ibus_req, 1'b0);
            cyc();
            chk("s6_wait_req_hold", ibus_if.ibus_req, 1'b0);
            chk("s6_one_buffered", dec_valid, 1'b1);
            dec_ready = 1'b1;
            cyc();
            dec_ready = 1'b0;
        end
        chk("s6_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
